exc_ctrl: RTL and testbench

- Exception sequencing controller for the single-cycle LEGv8 core with exceptions.
- Arbitrates simultaneous exception sources by fixed priority and captures the return PC into ELR and the cause into ESR, using enable flops.
- Steers next-PC selection to the vector, to ELR on ERET, or to PC+4, and detects double faults.
- Sits between the decode/memory-stage fault signals and the fetch PC mux.

---
 rtl/exc_pkg.sv | 36 +++
 rtl/flopr_e.sv | 23 ++
 rtl/exc_ctrl.sv | 169 ++++++++++++++++
 tb/tb_exc_ctrl.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/exc_pkg.sv
// Shared types and constants for the LEGv8 exception controller.
package exc_pkg;

  // Controller state: normal execution, inside a handler, or stopped on a double fault.
  typedef enum logic [1:0] {
    RUN     = 2'd0,
    HANDLER = 2'd1,
    HALT    = 2'd2
  } exc_state_t;

  // Cause codes recorded in ESR.
  localparam logic [3:0] EXC_INVOP = 4'h1;
  localparam logic [3:0] EXC_IRQ   = 4'h2;
  localparam logic [3:0] EXC_MEMF  = 4'h3;
  localparam logic [3:0] EXC_DBL   = 4'hF;

  // Encodings of the fetch next-PC mux select.
  localparam logic [1:0] PCSEL_SEQ = 2'b00;
  localparam logic [1:0] PCSEL_VEC = 2'b01;
  localparam logic [1:0] PCSEL_ELR = 2'b10;

  // Fixed-priority cause selection: memory fault beats an illegal opcode,
  // and an external interrupt only wins when neither synchronous fault is present.
  function automatic logic [3:0] exc_cause(input logic mem_fault, input logic invalid_op);
    logic [3:0] code;
    if (mem_fault) begin
      code = EXC_MEMF;
    end else if (invalid_op) begin
      code = EXC_INVOP;
    end else begin
      code = EXC_IRQ;
    end
    return code;
  endfunction

endpackage

// File: rtl/flopr_e.sv
// Enable flop with asynchronous active-high reset; holds its value while en is low.
module flopr_e #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  // Load d on enabled clock edges, clear asynchronously on reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      q <= '0;
    end else if (en) begin
      q <= d;
    end else begin
      q <= q;
    end
  end

endmodule

// File: rtl/exc_ctrl.sv
// Exception sequencing controller for the single-cycle LEGv8 core.
// Arbitrates fault/interrupt sources, captures ELR/ESR, steers the fetch PC
// mux and detects double faults.
// Optional build macro: EXC_STATS_EN adds a saturating exc_count output.
module exc_ctrl
  import exc_pkg::*;
#(
  parameter int          N        = 64,
  parameter logic [63:0] VEC_ADDR = 64'h00000000000000D8,
  parameter int          ESR_W    = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N-1:0]     pc_i,
  input  logic             invalid_op,
  input  logic             mem_fault,
  input  logic             ext_irq,
  input  logic             eret,
  output logic [1:0]       pc_sel,
  output logic [N-1:0]     exc_vec,
  output logic [N-1:0]     elr_o,
  output logic [ESR_W-1:0] esr_o,
  output logic             exc_taken,
  output logic             flush,
  output logic             halted
`ifdef EXC_STATS_EN
  ,
  output logic [15:0]      exc_count
`endif
);

  exc_state_t       state_q, state_d;
  logic             irq_pend_q, irq_pend_d;
  logic             guard_q, guard_d;

  logic             rst_s;
  logic             sync_fault_s;
  logic             irq_req_s;
  logic             take_s;
  logic [1:0]       pc_sel_s;
  logic             exc_taken_s;
  logic             flush_s;
  logic             halted_s;
  logic             elr_en_s;
  logic             esr_en_s;
  logic [ESR_W-1:0] esr_d;

  assign rst_s   = ~reset;
  assign exc_vec = VEC_ADDR[N-1:0];

  // In RUN an ERET is illegal and is folded into the invalid-opcode fault.
  assign sync_fault_s = mem_fault | invalid_op | eret;
  assign irq_req_s    = (ext_irq | irq_pend_q) & ~guard_q;
  assign take_s       = sync_fault_s | irq_req_s;

  // Next-state and output decode; every output takes its idle value first.
  always_comb begin
    state_d     = state_q;
    irq_pend_d  = irq_pend_q;
    guard_d     = guard_q;
    pc_sel_s    = PCSEL_SEQ;
    exc_taken_s = 1'b0;
    flush_s     = 1'b0;
    halted_s    = 1'b0;
    elr_en_s    = 1'b0;
    esr_en_s    = 1'b0;
    esr_d       = esr_o;
    case (state_q)
      RUN: begin
        guard_d = 1'b0;
        if (take_s) begin
          exc_taken_s = 1'b1;
          flush_s     = 1'b1;
          pc_sel_s    = PCSEL_VEC;
          elr_en_s    = 1'b1;
          esr_en_s    = 1'b1;
          esr_d       = ESR_W'(exc_cause(mem_fault, invalid_op | eret));
          state_d     = HANDLER;
          if (sync_fault_s) begin
            // The interrupt lost arbitration: remember it for later.
            irq_pend_d = irq_pend_q | ext_irq;
          end else begin
            irq_pend_d = 1'b0;
          end
        end else begin
          irq_pend_d = irq_pend_q | ext_irq;
        end
      end
      HANDLER: begin
        // Interrupts are masked inside the handler; only latch them.
        irq_pend_d = irq_pend_q | ext_irq;
        if (mem_fault | invalid_op) begin
          flush_s  = 1'b1;
          esr_en_s = 1'b1;
          esr_d    = ESR_W'(EXC_DBL);
          state_d  = HALT;
        end else if (eret) begin
          // guard lets the returned-to instruction retire before a pending IRQ.
          pc_sel_s = PCSEL_ELR;
          guard_d  = 1'b1;
          state_d  = RUN;
        end else begin
          state_d = HANDLER;
        end
      end
      HALT: begin
        halted_s = 1'b1;
        flush_s  = 1'b1;
        state_d  = HALT;
      end
      default: begin
        state_d = RUN;
      end
    endcase
  end

  // Controller state registers with asynchronous reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= RUN;
      irq_pend_q <= 1'b0;
      guard_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      irq_pend_q <= irq_pend_d;
      guard_q    <= guard_d;
    end
  end

  // Outputs are forced idle while reset is asserted, independent of inputs.
  assign pc_sel    = reset ? pc_sel_s : 2'b00;
  assign exc_taken = reset & exc_taken_s;
  assign flush     = reset & flush_s;
  assign halted    = reset & halted_s;

  flopr_e #(.WIDTH(N)) u_elr (
    .clk   (clk),
    .reset (rst_s),
    .en    (elr_en_s),
    .d     (pc_i),
    .q     (elr_o)
  );

  flopr_e #(.WIDTH(ESR_W)) u_esr (
    .clk   (clk),
    .reset (rst_s),
    .en    (esr_en_s),
    .d     (esr_d),
    .q     (esr_o)
  );

`ifdef EXC_STATS_EN
  logic [15:0] exc_count_q;

  // Count taken exceptions, saturating at the top of the range.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      exc_count_q <= 16'h0000;
    end else if (exc_taken_s && (exc_count_q != 16'hFFFF)) begin
      exc_count_q <= exc_count_q + 16'h0001;
    end else begin
      exc_count_q <= exc_count_q;
    end
  end

  assign exc_count = exc_count_q;
`endif

endmodule

// File: tb/tb_exc_ctrl.sv
// Directed self-checking bench for exc_ctrl.
module tb_exc_ctrl;

  logic        clk;
  logic        reset;
  logic [63:0] pc_i;
  logic        invalid_op;
  logic        mem_fault;
  logic        ext_irq;
  logic        eret;
  logic [1:0]  pc_sel;
  logic [63:0] exc_vec;
  logic [63:0] elr_o;
  logic [3:0]  esr_o;
  logic        exc_taken;
  logic        flush;
  logic        halted;
`ifdef EXC_STATS_EN
  logic [15:0] exc_count;
`endif

  int tests = 0;
  int fails = 0;

  exc_ctrl dut (
    .clk        (clk),
    .reset      (reset),
    .pc_i       (pc_i),
    .invalid_op (invalid_op),
    .mem_fault  (mem_fault),
    .ext_irq    (ext_irq),
    .eret       (eret),
    .pc_sel     (pc_sel),
    .exc_vec    (exc_vec),
    .elr_o      (elr_o),
    .esr_o      (esr_o),
    .exc_taken  (exc_taken),
    .flush      (flush),
    .halted     (halted)
`ifdef EXC_STATS_EN
    ,
    .exc_count  (exc_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic clear_inputs();
    invalid_op = 1'b0;
    mem_fault  = 1'b0;
    ext_irq    = 1'b0;
    eret       = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    clear_inputs();
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    clear_inputs();
    pc_i = 64'h100;
    @(negedge clk);
    #1;
    tests++; if (exc_vec !== 64'hD8) begin fails++; $display("FAIL rst_vec: got %h want %h", exc_vec, 64'hD8); end
    tests++; if (pc_sel !== 2'b00) begin fails++; $display("FAIL rst_pcsel: got %b want 00", pc_sel); end
    @(negedge clk);
    reset = 1'b1;
    #1;
    tests++; if (pc_sel !== 2'b00) begin fails++; $display("FAIL rel_pcsel: got %b want 00", pc_sel); end
    tests++; if (elr_o !== 64'h0) begin fails++; $display("FAIL rel_elr: got %h want 0", elr_o); end
    tests++; if (esr_o !== 4'h0) begin fails++; $display("FAIL rel_esr: got %h want 0", esr_o); end
    tests++; if (halted !== 1'b0) begin fails++; $display("FAIL rel_halted: got %b want 0", halted); end
    tests++; if (exc_taken !== 1'b0) begin fails++; $display("FAIL rel_taken: got %b want 0", exc_taken); end
    @(posedge clk); #1;
    tests++; if (esr_o !== 4'h0 || pc_sel !== 2'b00) begin fails++; $display("FAIL idle_run: esr %h pc_sel %b want 0/00", esr_o, pc_sel); end
  endtask

  task automatic test_invalid_op();
    do_reset();
    @(negedge clk);
    pc_i = 64'h0123456789ABCDEF; invalid_op = 1'b1;
    #1;
    tests++; if (exc_taken !== 1'b1) begin fails++; $display("FAIL inv_taken: got %b want 1", exc_taken); end
    tests++; if (pc_sel !== 2'b01) begin fails++; $display("FAIL inv_pcsel: got %b want 01", pc_sel); end
    tests++; if (flush !== 1'b1) begin fails++; $display("FAIL inv_flush: got %b want 1", flush); end
    @(posedge clk); #1;
    tests++; if (elr_o !== 64'h0123456789ABCDEF) begin fails++; $display("FAIL inv_elr: got %h want 0123456789abcdef", elr_o); end
    tests++; if (esr_o !== 4'h1) begin fails++; $display("FAIL inv_esr: got %h want 1", esr_o); end
    @(negedge clk);
    invalid_op = 1'b0; eret = 1'b1; pc_i = 64'h2000;
    #1;
    tests++; if (pc_sel !== 2'b10) begin fails++; $display("FAIL eret_pcsel: got %b want 10", pc_sel); end
    tests++; if (exc_taken !== 1'b0) begin fails++; $display("FAIL eret_taken: got %b want 0", exc_taken); end
    @(negedge clk);
    eret = 1'b0; pc_i = 64'h0123456789ABCDF3;
    #1;
    tests++; if (pc_sel !== 2'b00 || halted !== 1'b0) begin fails++; $display("FAIL ret_run: pc_sel %b halted %b want 00/0", pc_sel, halted); end
    // ERET while in RUN is an invalid opcode.
    @(negedge clk);
    eret = 1'b1; pc_i = 64'h300;
    #1;
    tests++; if (exc_taken !== 1'b1 || pc_sel !== 2'b01) begin fails++; $display("FAIL eret_run_take: taken %b pc_sel %b want 1/01", exc_taken, pc_sel); end
    @(posedge clk); #1;
    tests++; if (esr_o !== 4'h1 || elr_o !== 64'h300) begin fails++; $display("FAIL eret_run_cap: esr %h elr %h want 1/300", esr_o, elr_o); end
    @(negedge clk);
    clear_inputs();
  endtask

  task automatic test_memf_irq();
    do_reset();
    @(negedge clk);
    pc_i = 64'h40; mem_fault = 1'b1; ext_irq = 1'b1;
    #1;
    tests++; if (exc_taken !== 1'b1) begin fails++; $display("FAIL mf_taken: got %b want 1", exc_taken); end
    @(posedge clk); #1;
    tests++; if (esr_o !== 4'h3 || elr_o !== 64'h40) begin fails++; $display("FAIL mf_cap: esr %h elr %h want 3/40", esr_o, elr_o); end
    @(negedge clk);
    mem_fault = 1'b0; ext_irq = 1'b0; eret = 1'b1; pc_i = 64'h800;
    #1;
    tests++; if (pc_sel !== 2'b10 || exc_taken !== 1'b0) begin fails++; $display("FAIL mf_eret: pc_sel %b taken %b want 10/0", pc_sel, exc_taken); end
    @(negedge clk);
    eret = 1'b0; pc_i = 64'h44;
    #1;
    tests++; if (exc_taken !== 1'b0 || pc_sel !== 2'b00) begin fails++; $display("FAIL mf_retire: taken %b pc_sel %b want 0/00", exc_taken, pc_sel); end
    @(posedge clk); #1;
    tests++; if (esr_o !== 4'h3) begin fails++; $display("FAIL mf_hold_esr: got %h want 3", esr_o); end
    @(negedge clk);
    pc_i = 64'h48;
    #1;
    tests++; if (exc_taken !== 1'b1 || pc_sel !== 2'b01) begin fails++; $display("FAIL irq_take: taken %b pc_sel %b want 1/01", exc_taken, pc_sel); end
    @(posedge clk); #1;
    tests++; if (esr_o !== 4'h2 || elr_o !== 64'h48) begin fails++; $display("FAIL irq_cap: esr %h elr %h want 2/48", esr_o, elr_o); end
    @(negedge clk);
    clear_inputs();
  endtask

  task automatic test_irq_masked();
    do_reset();
    @(negedge clk);
    pc_i = 64'h60; invalid_op = 1'b1; ext_irq = 1'b1;
    @(posedge clk); #1;
    tests++; if (esr_o !== 4'h1) begin fails++; $display("FAIL msk_entry_esr: got %h want 1", esr_o); end
    @(negedge clk);
    invalid_op = 1'b0; pc_i = 64'h900;
    for (int i = 0; i < 3; i++) begin
      #1;
      tests++; if (exc_taken !== 1'b0) begin fails++; $display("FAIL msk_handler_taken%0d: got %b want 0", i, exc_taken); end
      @(negedge clk);
    end
    eret = 1'b1;
    #1;
    tests++; if (pc_sel !== 2'b10 || exc_taken !== 1'b0) begin fails++; $display("FAIL msk_eret: pc_sel %b taken %b want 10/0", pc_sel, exc_taken); end
    @(negedge clk);
    eret = 1'b0; pc_i = 64'h64;
    #1;
    tests++; if (exc_taken !== 1'b0) begin fails++; $display("FAIL msk_guard: got %b want 0", exc_taken); end
    @(negedge clk);
    pc_i = 64'h68;
    #1;
    tests++; if (exc_taken !== 1'b1) begin fails++; $display("FAIL msk_take: got %b want 1", exc_taken); end
    @(posedge clk); #1;
    tests++; if (esr_o !== 4'h2 || elr_o !== 64'h68) begin fails++; $display("FAIL msk_cap: esr %h elr %h want 2/68", esr_o, elr_o); end
    @(negedge clk);
    clear_inputs();
  endtask

  task automatic test_double_fault();
    do_reset();
    @(negedge clk);
    pc_i = 64'h80; invalid_op = 1'b1;
    @(negedge clk);
    invalid_op = 1'b0; mem_fault = 1'b1; pc_i = 64'hA00;
    #1;
    tests++; if (flush !== 1'b1 || exc_taken !== 1'b0) begin fails++; $display("FAIL dbl_comb: flush %b taken %b want 1/0", flush, exc_taken); end
    @(posedge clk); #1;
    tests++; if (esr_o !== 4'hF || elr_o !== 64'h80 || halted !== 1'b1) begin fails++; $display("FAIL dbl_cap: esr %h elr %h halted %b want f/80/1", esr_o, elr_o, halted); end
    @(negedge clk);
    mem_fault = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk); #1;
      tests++; if (halted !== 1'b1 || flush !== 1'b1 || pc_sel !== 2'b00) begin fails++; $display("FAIL dbl_hold%0d: halted %b flush %b pc_sel %b want 1/1/00", i, halted, flush, pc_sel); end
    end
    reset = 1'b0;
    #1;
    tests++; if (halted !== 1'b0 || esr_o !== 4'h0 || elr_o !== 64'h0) begin fails++; $display("FAIL dbl_rst: halted %b esr %h elr %h want 0/0/0", halted, esr_o, elr_o); end
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    pc_i = 64'hB0; invalid_op = 1'b1;
    #1;
    tests++; if (exc_taken !== 1'b1) begin fails++; $display("FAIL dbl_run_again: got %b want 1", exc_taken); end
    @(negedge clk);
    clear_inputs();
  endtask

  task automatic test_async_reset();
    do_reset();
    @(negedge clk);
    pc_i = 64'hC0; invalid_op = 1'b1;
    @(negedge clk);
    invalid_op = 1'b0; eret = 1'b1;
    #1;
    tests++; if (pc_sel !== 2'b10) begin fails++; $display("FAIL ar_pre: got %b want 10", pc_sel); end
    #2;
    reset = 1'b0;
    #1;
    tests++; if (pc_sel !== 2'b00 || elr_o !== 64'h0 || esr_o !== 4'h0) begin fails++; $display("FAIL ar_regs: pc_sel %b elr %h esr %h want 00/0/0", pc_sel, elr_o, esr_o); end
    tests++; if (exc_taken !== 1'b0 || flush !== 1'b0 || halted !== 1'b0) begin fails++; $display("FAIL ar_ctl: taken %b flush %b halted %b want 0/0/0", exc_taken, flush, halted); end
    @(negedge clk);
    clear_inputs();
    reset = 1'b1;
    #1;
    tests++; if (pc_sel !== 2'b00 || exc_taken !== 1'b0) begin fails++; $display("FAIL ar_run: pc_sel %b taken %b want 00/0", pc_sel, exc_taken); end
  endtask

`ifdef EXC_STATS_EN
  task automatic test_stats();
    do_reset();
    #1;
    tests++; if (exc_count !== 16'd0) begin fails++; $display("FAIL cnt_rst: got %0d want 0", exc_count); end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      pc_i = 64'h1000 + 64'(i); invalid_op = 1'b1;
      @(negedge clk);
      invalid_op = 1'b0; eret = 1'b1;
      @(negedge clk);
      eret = 1'b0;
    end
    @(posedge clk); #1;
    tests++; if (exc_count !== 16'd3) begin fails++; $display("FAIL cnt_three: got %0d want 3", exc_count); end
  endtask
`endif

  initial begin
    pc_i = 64'h0;
    clear_inputs();
    test_reset();
    test_invalid_op();
    test_memf_irq();
    test_irq_masked();
    test_double_fault();
    test_async_reset();
`ifdef EXC_STATS_EN
    test_stats();
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
